idelay_loader: RTL and testbench
================================

Name: idelay_loader

Overview:
- Control-side sequencer directly upstream of a bank of IDELAYE2 wrappers running in VAR_LOAD_PIPE mode.
- Accepts per-lane delay write commands and "apply" commands over a valid/ready interface.
- For each write, drives the lane's 5-bit delay bus and pulses that lane's ld (LDPIPEEN), which stages the value in the pipe register.
- On apply, after a settle interval, issues one common set (LD) pulse so all staged lanes switch delay in the same cycle.

Parameters:
- NUM_LANES, 8, number of delay lanes driven.
- LANE_BITS, 3, width of the lane index; 2**LANE_BITS >= NUM_LANES.
- INIT_DELAY, 0, reset tap value (0..31); must equal DELAY_VALUE of the driven wrappers.
- SETTLE_CYCLES, 2, cycles waited before the set pulse and again after it (range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_apply  in  1  1 = apply command (cmd_lane and cmd_delay ignored); 0 = write command.
- cmd_lane  in  LANE_BITS  target lane of a write.
- cmd_delay  in  5  tap value of a write.
- dly_out  out  NUM_LANES*5  per-lane delay bus; lane i occupies bits [5i+4:5i].
- ld_out  out  NUM_LANES  per-lane one-cycle LDPIPEEN strobe.
- set_out  out  1  common one-cycle LD strobe.
- applied  out  NUM_LANES*5  tap values currently in effect, same lane packing as dly_out.
- pending  out  NUM_LANES  lanes staged but not yet applied.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky flag: a write addressed lane >= NUM_LANES.

Behaviour:
- Reset (async assert, rst=0):
  - state=IDLE.
  - dly_out and applied = INIT_DELAY replicated per lane.
  - ld_out, set_out, pending, err, busy = 0.
- cmd_ready = (state==IDLE). It is combinational from registered state, so it is 1 in the first cycle after reset release.
- FSM states: IDLE, LOAD, PRE, SET, POST.
- Write accepted in IDLE:
  - Valid lane: at the next edge, dly_out[lane] <= cmd_delay and state->LOAD.
  - In LOAD, ld_out[lane]=1 for exactly one cycle, with dly_out already stable in that cycle. At the end of LOAD, pending[lane] <= 1 and state->IDLE.
  - Throughput is one write per 2 cycles.
  - Rewriting a pending lane overwrites its staged value; the last write wins.
- Write with lane >= NUM_LANES:
  - Accepted; err <= 1; no dly_out or ld_out change.
  - State goes through LOAD with ld_out=0, so timing is identical to a valid write.
- Apply accepted with pending==0: no-op. State stays IDLE, no set_out, and cmd_ready stays 1.
- Apply accepted with pending!=0:
  - state->PRE for SETTLE_CYCLES cycles, counted by a 4-bit down-counter.
  - Then SET for 1 cycle: set_out=1, and in the same edge applied[i] <= dly_out[i] for each pending lane, pending <= 0.
  - Then POST for SETTLE_CYCLES cycles, then IDLE.
  - Total busy span = 2*SETTLE_CYCLES + 1 cycles.
- set_out affects all lanes. Non-pending lanes still hold their applied value in the pipe register, so they are unchanged.
- ld_out and set_out are never asserted in the same cycle, and at most one ld_out bit is high in any cycle.
- cmd_valid is ignored while busy. No command is dropped silently: the source must hold cmd_valid until cmd_ready.
- Async reset mid-operation (any state) returns every output to its reset value immediately. No set_out is issued afterwards for the lost pending lanes.
- Every output except cmd_ready is a direct register output.

Decomposition:
- Shared package (idelay_pkg) holds:
  - the FSM state enum;
  - DLY_W=5 (tap width);
  - SETTLE_W=4 (settle counter width).
- No sub-module. The settle counter and lane decode stay inline; the lane-packing slice helper function goes in the package.

Test Plan:
- Reset release, INIT_DELAY=3 -> dly_out and applied all lanes = 3; pending=0; cmd_ready=1 in the first cycle.
- Write lane 2 delay 17 -> dly_out[14:10]=17 one cycle after acceptance; ld_out=0x04 for exactly that cycle; pending=0x04; cmd_ready low for 1 cycle.
- Writes lane0=5, lane7=31, then apply with SETTLE_CYCLES=2:
  - set_out high exactly 3 cycles after apply acceptance, for 1 cycle;
  - applied lane0=5, lane7=31, others unchanged;
  - pending=0; busy for 5 cycles.
- Apply with pending=0 -> no set_out, busy never asserted, cmd_ready stays 1.
- Write lane 9 with NUM_LANES=8, LANE_BITS=4 -> err=1 stays set; ld_out and dly_out unchanged; LOAD-cycle timing preserved.
- rst asserted during PRE after staging lane 1=12 -> outputs return to reset values immediately; no set_out after release; applied lane 1 = INIT_DELAY.

Source files
------------

// File: rtl/idelay_pkg.sv
// Shared definitions for the IDELAYE2 load sequencer.
// Contents:
//   state_e  - sequencer FSM states
//   DLY_W    - tap value width of one delay lane
//   SETTLE_W - width of the settle down-counter
//   lane_lsb - bit offset of a lane inside a packed NUM_LANES*DLY_W bus
package idelay_pkg;

    localparam int DLY_W    = 5;
    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PRE  = 3'd2,
        SET  = 3'd3,
        POST = 3'd4
    } state_e;

    // Lane i occupies bits [DLY_W*i + DLY_W-1 : DLY_W*i] of a packed bus.
    function automatic int lane_lsb(input int lane);
        return lane * DLY_W;
    endfunction

endpackage

// File: rtl/idelay_loader.sv
// Control-side sequencer for a bank of IDELAYE2 wrappers in VAR_LOAD_PIPE mode.
// Write commands stage a tap value into one lane's pipe register (dly_out plus
// a one-cycle ld_out strobe). An apply command waits SETTLE_CYCLES, fires one
// common set_out strobe so every staged lane switches in the same cycle, then
// waits SETTLE_CYCLES again before accepting the next command.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   cmd_valid/ready   - command handshake (ready only in IDLE)
//   cmd_apply         - 1 = apply, 0 = write of cmd_delay to cmd_lane
//   dly_out, ld_out   - per-lane delay bus and LDPIPEEN strobes
//   set_out           - common LD strobe
//   applied, pending  - taps in effect / lanes staged but not applied
//   busy, err         - not in IDLE / sticky out-of-range lane write
module idelay_loader
    import idelay_pkg::*;
#(
    parameter int NUM_LANES     = 8,
    parameter int LANE_BITS     = 3,
    parameter int INIT_DELAY    = 0,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_apply,
    input  logic [LANE_BITS-1:0]         cmd_lane,
    input  logic [DLY_W-1:0]             cmd_delay,
    output logic [NUM_LANES*DLY_W-1:0]   dly_out,
    output logic [NUM_LANES-1:0]         ld_out,
    output logic                         set_out,
    output logic [NUM_LANES*DLY_W-1:0]   applied,
    output logic [NUM_LANES-1:0]         pending,
    output logic                         busy,
    output logic                         err
);

    localparam logic [DLY_W-1:0]    INIT_TAP    = DLY_W'(INIT_DELAY);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e                state_r;
    logic [SETTLE_W-1:0]   cnt_r;
    logic                  lane_ok_s;
    logic [NUM_LANES-1:0]  lane_hot_s;

    assign cmd_ready = (state_r == IDLE);

    // Decode the write target: range check and one-hot strobe pattern.
    always_comb begin
        lane_ok_s  = ({{(32-LANE_BITS){1'b0}}, cmd_lane} < 32'(NUM_LANES));
        lane_hot_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_ok_s && ({{(32-LANE_BITS){1'b0}}, cmd_lane} == 32'(i))) begin
                lane_hot_s[i] = 1'b1;
            end else begin
                lane_hot_s[i] = 1'b0;
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            dly_out <= {NUM_LANES{INIT_TAP}};
            applied <= {NUM_LANES{INIT_TAP}};
            ld_out  <= '0;
            set_out <= 1'b0;
            pending <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ld_out  <= '0;
                    set_out <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd_apply) begin
                            // Apply with nothing staged is a no-op.
                            if (|pending) begin
                                state_r <= PRE;
                                cnt_r   <= SETTLE_LOAD;
                                busy    <= 1'b1;
                            end else begin
                                busy    <= 1'b0;
                            end
                        end else begin
                            // Bad lanes still pass through LOAD so write timing
                            // does not depend on the lane index.
                            state_r <= LOAD;
                            busy    <= 1'b1;
                            ld_out  <= lane_hot_s;
                            if (lane_ok_s) begin
                                dly_out[lane_lsb(int'(cmd_lane)) +: DLY_W] <= cmd_delay;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    // ld_out holds the strobed lane (or nothing for a bad lane).
                    pending <= pending | ld_out;
                    ld_out  <= '0;
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                PRE: begin
                    if (cnt_r == '0) begin
                        state_r <= SET;
                        set_out <= 1'b1;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (pending[i]) begin
                                applied[lane_lsb(i) +: DLY_W] <= dly_out[lane_lsb(i) +: DLY_W];
                            end
                        end
                        pending <= '0;
                    end else begin
                        cnt_r <= cnt_r - SETTLE_W'(1);
                    end
                end
                SET: begin
                    set_out <= 1'b0;
                    state_r <= POST;
                    cnt_r   <= SETTLE_LOAD;
                end
                POST: begin
                    if (cnt_r == '0) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - SETTLE_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ld_out  <= '0;
                    set_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idelay_loader.sv
// Directed bench for idelay_loader (NUM_LANES=8, LANE_BITS=4, INIT_DELAY=3,
// SETTLE_CYCLES=2). Inputs change and outputs are sampled 1 time unit after
// each rising edge; expected values are kept in a small local model.
module tb_idelay_loader;
    import idelay_pkg::*;

    localparam int NL = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_apply = 1'b0;
    logic [3:0]        cmd_lane = 4'd0;
    logic [4:0]        cmd_delay = 5'd0;
    logic [NL*5-1:0]   dly_out;
    logic [NL-1:0]     ld_out;
    logic              set_out;
    logic [NL*5-1:0]   applied;
    logic [NL-1:0]     pending;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [NL*5-1:0] exp_dly;
    logic [NL*5-1:0] exp_app;
    int set_seen;

    idelay_loader #(
        .NUM_LANES(8), .LANE_BITS(4), .INIT_DELAY(3), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_apply(cmd_apply), .cmd_lane(cmd_lane), .cmd_delay(cmd_delay),
        .dly_out(dly_out), .ld_out(ld_out), .set_out(set_out),
        .applied(applied), .pending(pending), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one write for one edge; returns in the LOAD cycle.
    task automatic write_cmd(input logic [3:0] lane, input logic [4:0] dly);
        cmd_valid = 1'b1; cmd_apply = 1'b0; cmd_lane = lane; cmd_delay = dly;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        exp_dly = {NL{5'd3}};
        exp_app = {NL{5'd3}};

        // Reset state
        tick(); tick();
        chk("rst_dly", 64'(dly_out), 64'(exp_dly));
        chk("rst_app", 64'(applied), 64'(exp_app));
        chk("rst_pend", 64'(pending), 64'h0);
        chk("rst_ld_set_busy_err", 64'({ld_out, set_out, busy, err}), 64'h0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(cmd_ready), 64'h1);

        // Write lane 2 = 17
        write_cmd(4'd2, 5'd17);
        exp_dly[10 +: 5] = 5'd17;
        chk("w2_dly", 64'(dly_out), 64'(exp_dly));
        chk("w2_ld", 64'(ld_out), 64'h04);
        chk("w2_ready_low", 64'({cmd_ready, busy}), 64'b01);
        chk("w2_pend_in_load", 64'(pending), 64'h0);
        tick();
        chk("w2_ld_off", 64'(ld_out), 64'h0);
        chk("w2_pend", 64'(pending), 64'h04);
        chk("w2_ready_back", 64'({cmd_ready, busy}), 64'b10);

        // Writes lane 0 = 5, lane 7 = 31, then apply
        write_cmd(4'd0, 5'd5);
        chk("w0_ld", 64'(ld_out), 64'h01);
        tick();
        write_cmd(4'd7, 5'd31);
        chk("w7_ld", 64'(ld_out), 64'h80);
        tick();
        exp_dly[0 +: 5]  = 5'd5;
        exp_dly[35 +: 5] = 5'd31;
        chk("w07_dly", 64'(dly_out), 64'(exp_dly));
        chk("w07_pend", 64'(pending), 64'h85);
        chk("pre_apply_app", 64'(applied), 64'(exp_app));

        cmd_valid = 1'b1; cmd_apply = 1'b1;
        tick();                                   // cycle 1 (PRE)
        cmd_valid = 1'b0; cmd_apply = 1'b0;
        chk("ap_c1", 64'({busy, cmd_ready, set_out}), 64'b100);
        tick();                                   // cycle 2 (PRE)
        chk("ap_c2", 64'({busy, cmd_ready, set_out}), 64'b100);
        tick();                                   // cycle 3 (SET)
        exp_app[0 +: 5]  = 5'd5;
        exp_app[10 +: 5] = 5'd17;
        exp_app[35 +: 5] = 5'd31;
        chk("ap_c3_set", 64'({busy, set_out, ld_out}), 64'({1'b1, 1'b1, 8'h00}));
        chk("ap_applied", 64'(applied), 64'(exp_app));
        chk("ap_pend_clr", 64'(pending), 64'h0);
        tick();                                   // cycle 4 (POST)
        chk("ap_c4", 64'({busy, set_out}), 64'b10);
        tick();                                   // cycle 5 (POST)
        chk("ap_c5", 64'({busy, set_out}), 64'b10);
        tick();                                   // back in IDLE
        chk("ap_c6_idle", 64'({busy, cmd_ready, set_out}), 64'b010);

        // Apply with nothing pending
        cmd_valid = 1'b1; cmd_apply = 1'b1;
        tick();
        chk("nop_ap_1", 64'({busy, cmd_ready, set_out}), 64'b010);
        tick();
        cmd_valid = 1'b0; cmd_apply = 1'b0;
        chk("nop_ap_2", 64'({busy, cmd_ready, set_out}), 64'b010);
        tick();
        chk("nop_ap_3", 64'({busy, set_out}), 64'b00);
        chk("nop_ap_app", 64'(applied), 64'(exp_app));

        // Out-of-range lane 9
        write_cmd(4'd9, 5'd20);
        chk("bad_err", 64'(err), 64'h1);
        chk("bad_ld", 64'(ld_out), 64'h0);
        chk("bad_dly", 64'(dly_out), 64'(exp_dly));
        chk("bad_load_timing", 64'({busy, cmd_ready}), 64'b10);
        tick();
        chk("bad_idle", 64'({busy, cmd_ready, err}), 64'b011);
        chk("bad_pend", 64'(pending), 64'h0);
        write_cmd(4'd1, 5'd12);                    // err stays set on a good write
        chk("err_sticky", 64'(err), 64'h1);
        exp_dly[5 +: 5] = 5'd12;
        chk("w1_ld", 64'(ld_out), 64'h02);
        tick();
        chk("w1_pend", 64'(pending), 64'h02);

        // Reset during PRE with lane 1 staged
        cmd_valid = 1'b1; cmd_apply = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_apply = 1'b0;
        chk("mid_pre_busy", 64'(busy), 64'h1);
        rst = 1'b0;
        #1;
        exp_dly = {NL{5'd3}};
        exp_app = {NL{5'd3}};
        chk("mid_rst_dly", 64'(dly_out), 64'(exp_dly));
        chk("mid_rst_app", 64'(applied), 64'(exp_app));
        chk("mid_rst_flags", 64'({pending, ld_out, set_out, busy, err}), 64'h0);
        tick(); tick();
        rst = 1'b1;
        set_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (set_out) set_seen++;
        end
        chk("mid_no_set", 64'(set_seen), 64'h0);
        chk("mid_lane1_app", 64'(applied[5 +: 5]), 64'h3);
        chk("mid_idle", 64'({busy, cmd_ready}), 64'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
